// File: rtl/v2_peak_detector.sv
// ---------------------------------------------------------------------------
// v2_peak_detector
//
// Pulse-height analyser fed by the v2 trapezoidal shaping filter. It finds
// pulses that rise strictly above a signed threshold and measures each one:
// the peak amplitude, the timestamp of the peak sample and the number of
// samples above threshold. Each accepted pulse becomes one event on a
// valid/ready interface.
//
// Optional build macro: PEAK_PILEUP_REJECT_EN
//   defined   - flags pile-up: a pulse that falls and then rises again
//               while still above threshold sets ev_pileup.
//   undefined - no pile-up logic; ev_pileup is tied to 0.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   enable       detection enable; when low, any pulse in progress is dropped
//   filter_data  signed filter sample, one per clock
//   threshold    signed trigger level, sampled only while idle
//   ev_valid     event available
//   ev_ready     consumer accepts the event
//   ev_amplitude peak value of the pulse
//   ev_time      timestamp of the peak sample
//   ev_width     samples strictly above threshold (saturating)
//   ev_pileup    pile-up flag
//   lost_count   events dropped because the output was busy (saturating)
// ---------------------------------------------------------------------------
module v2_peak_detector #(
    parameter int SIZE_FILTER_DATA = 16,
    parameter int TS_WIDTH         = 32,
    parameter int WIDTH_BITS       = 8,
    parameter int MIN_WIDTH        = 2,
    parameter int HOLDOFF_LEN      = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
    input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
    output logic                               ev_valid,
    input  logic                               ev_ready,
    output logic signed [SIZE_FILTER_DATA-1:0] ev_amplitude,
    output logic        [TS_WIDTH-1:0]         ev_time,
    output logic        [WIDTH_BITS-1:0]       ev_width,
    output logic                               ev_pileup,
    output logic        [15:0]                 lost_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RISE    = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam int              HC_W    = (HOLDOFF_LEN > 1) ? $clog2(HOLDOFF_LEN) : 1;
    localparam logic [HC_W-1:0] HC_LAST = (HOLDOFF_LEN > 0) ? HC_W'(HOLDOFF_LEN - 1) : '0;
    // With no dead time a finished pulse goes straight back to idle.
    localparam state_t          ST_AFTER = (HOLDOFF_LEN == 0) ? ST_IDLE : ST_HOLDOFF;

    state_t                             state_r;
    logic        [TS_WIDTH-1:0]         ts_r;
    logic signed [SIZE_FILTER_DATA-1:0] x_r;
    logic        [TS_WIDTH-1:0]         x_ts_r;
    logic signed [SIZE_FILTER_DATA-1:0] thr_r;
    logic signed [SIZE_FILTER_DATA-1:0] peak_r;
    logic        [TS_WIDTH-1:0]         peak_ts_r;
    logic        [WIDTH_BITS-1:0]       width_r;
    logic        [HC_W-1:0]             hold_cnt_r;
`ifdef PEAK_PILEUP_REJECT_EN
    logic signed [SIZE_FILTER_DATA-1:0] x_prev_r;
    logic                               falling_r;
    logic                               pileup_r;
`endif

    // Input stage: register the sample together with the timestamp it arrived at.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_r     <= '0;
            x_r      <= '0;
            x_ts_r   <= '0;
`ifdef PEAK_PILEUP_REJECT_EN
            x_prev_r <= '0;
`endif
        end else begin
            ts_r     <= ts_r + TS_WIDTH'(1);
            x_r      <= filter_data;
            x_ts_r   <= ts_r;
`ifdef PEAK_PILEUP_REJECT_EN
            x_prev_r <= x_r;
`endif
        end
    end

    // Pulse FSM, measurement registers and the registered event output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            thr_r        <= '0;
            peak_r       <= '0;
            peak_ts_r    <= '0;
            width_r      <= '0;
            hold_cnt_r   <= '0;
            ev_valid     <= 1'b0;
            ev_amplitude <= '0;
            ev_time      <= '0;
            ev_width     <= '0;
            lost_count   <= 16'd0;
`ifdef PEAK_PILEUP_REJECT_EN
            falling_r    <= 1'b0;
            pileup_r     <= 1'b0;
            ev_pileup    <= 1'b0;
`endif
        end else begin
            // A pop clears valid; a REPORT on the same edge reloads it below.
            if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
            if (state_r == ST_IDLE) begin
                thr_r <= threshold;
            end
            if (!enable) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (x_r > thr_r) begin
                            state_r   <= ST_RISE;
                            peak_r    <= x_r;
                            peak_ts_r <= x_ts_r;
                            width_r   <= WIDTH_BITS'(1);
`ifdef PEAK_PILEUP_REJECT_EN
                            falling_r <= 1'b0;
                            pileup_r  <= 1'b0;
`endif
                        end
                    end
                    ST_RISE: begin
                        if (x_r > thr_r) begin
                            if (width_r != '1) begin
                                width_r <= width_r + WIDTH_BITS'(1);
                            end
                            // Strictly greater: a tie keeps the earlier timestamp.
                            if (x_r > peak_r) begin
                                peak_r    <= x_r;
                                peak_ts_r <= x_ts_r;
                            end
`ifdef PEAK_PILEUP_REJECT_EN
                            if (x_r < x_prev_r) begin
                                falling_r <= 1'b1;
                            end else if (falling_r && (x_r > x_prev_r)) begin
                                pileup_r <= 1'b1;
                            end
`endif
                        end else if (width_r >= WIDTH_BITS'(MIN_WIDTH)) begin
                            state_r <= ST_REPORT;
                        end else begin
                            state_r    <= ST_AFTER;
                            hold_cnt_r <= '0;
                        end
                    end
                    ST_REPORT: begin
                        if (!ev_valid || ev_ready) begin
                            ev_valid     <= 1'b1;
                            ev_amplitude <= peak_r;
                            ev_time      <= peak_ts_r;
                            ev_width     <= width_r;
`ifdef PEAK_PILEUP_REJECT_EN
                            ev_pileup    <= pileup_r;
`endif
                        end else if (lost_count != 16'hFFFF) begin
                            lost_count <= lost_count + 16'd1;
                        end
                        state_r    <= ST_AFTER;
                        hold_cnt_r <= '0;
                    end
                    ST_HOLDOFF: begin
                        if (hold_cnt_r == HC_LAST) begin
                            state_r <= ST_IDLE;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + HC_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifndef PEAK_PILEUP_REJECT_EN
    assign ev_pileup = 1'b0;
`endif

endmodule

// File: tb/tb_v2_peak_detector.sv
module tb_v2_peak_detector;

    typedef struct packed {
        logic [15:0] amp;
        logic [31:0] t;
        logic [7:0]  w;
        logic        p;
    } ev_t;

`ifdef PEAK_PILEUP_REJECT_EN
    localparam logic PILE_EXP = 1'b1;
`else
    localparam logic PILE_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic               ev_ready = 1'b1;
    logic signed [15:0] filter_data = 16'sd0;
    logic signed [15:0] threshold = 16'sd100;
    logic               ev_valid;
    logic signed [15:0] ev_amplitude;
    logic [31:0]        ev_time;
    logic [7:0]         ev_width;
    logic               ev_pileup;
    logic [15:0]        lost_count;

    int   n_vec = 0;
    int   n_err = 0;
    ev_t  exp_q[$];
    ev_t  got[$];
    int   stim[$];
    logic [31:0] tb_ts;
    ev_t  e;
    ev_t  g;

    v2_peak_detector dut (
        .clk(clk), .reset(reset), .enable(enable),
        .filter_data(filter_data), .threshold(threshold),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_amplitude(ev_amplitude), .ev_time(ev_time),
        .ev_width(ev_width), .ev_pileup(ev_pileup),
        .lost_count(lost_count)
    );

    always #5 clk = ~clk;

    // Reference timestamp: zero out of reset, one count per clock.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ts <= 32'd0;
        else        tb_ts <= tb_ts + 32'd1;
    end

    // Record every handshake that will complete on the next rising edge.
    always @(negedge clk) begin
        if (reset && ev_valid && ev_ready)
            got.push_back(ev_t'({ev_amplitude, ev_time, ev_width, ev_pileup}));
    end

    task automatic drive(input int v);
        filter_data = 16'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic play();
        foreach (stim[i]) drive(stim[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({ev_valid, ev_pileup} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags got=%b required=00", {ev_valid, ev_pileup});
        end
        n_vec++;
        if ({ev_amplitude, ev_time, ev_width, lost_count} !== 72'd0) begin
            n_err++;
            $display("FAIL reset_fields got=%h required=0", {ev_amplitude, ev_time, ev_width, lost_count});
        end
        reset = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
    endtask

    task automatic test_basic();
        exp_q.push_back('{16'd300, tb_ts + 32'd3, 8'd4, 1'b0});
        stim = '{0, 50, 150, 300, 200, 120, 90};
        play();
        // 90 captured at the last edge: valid must rise only after two more edges.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (ev_valid !== (k == 2)) begin
                n_err++;
                $display("FAIL basic_latency edge+%0d got=%b required=%b", k, ev_valid, (k == 2));
            end
        end
        idle(12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got.size() == 0) begin
                n_err++;
                $display("FAIL basic_event got=none required=%h", e);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL basic_event got=%h required=%h", g, e);
                end
            end
        end
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL basic_extra got=%0d required=0", got.size());
        end
        got.delete();
    endtask

    task automatic test_min_width();
        stim = '{0, 150, 0};
        play();
        idle(14);
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL min_width_events got=%0d required=0", got.size());
        end
        n_vec++;
        if (lost_count !== 16'd0) begin
            n_err++;
            $display("FAIL min_width_lost got=%0d required=0", lost_count);
        end
        got.delete();
    endtask

    task automatic test_enable();
        stim = '{0, 150, 300};
        play();
        enable = 1'b0;
        idle(2);
        enable = 1'b1;
        idle(14);
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL enable_drop got=%0d required=0", got.size());
        end
        got.delete();
    endtask

    task automatic test_pileup();
        exp_q.push_back('{16'd300, tb_ts + 32'd2, 8'd5, PILE_EXP});
        stim = '{0, 150, 300, 200, 250, 120, 0};
        play();
        idle(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got.size() == 0) begin
                n_err++;
                $display("FAIL pileup_event got=none required=%h", e);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL pileup_event got=%h required=%h", g, e);
                end
            end
        end
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL pileup_extra got=%0d required=0", got.size());
        end
        got.delete();
    endtask

    task automatic test_holdoff();
        // Pulse ends at index 4; 400 at index 7 falls in the dead time,
        // 400 at index 14 is the first sample that can trigger again.
        exp_q.push_back('{16'd300, tb_ts + 32'd2, 8'd3, 1'b0});
        exp_q.push_back('{16'd400, tb_ts + 32'd14, 8'd2, 1'b0});
        stim = '{0, 150, 300, 150, 0, 0, 0, 400, 400, 0, 0, 0, 0, 0, 400, 400, 0};
        play();
        idle(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got.size() == 0) begin
                n_err++;
                $display("FAIL holdoff_event got=none required=%h", e);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL holdoff_event got=%h required=%h", g, e);
                end
            end
        end
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL holdoff_extra got=%0d required=0", got.size());
        end
        got.delete();
    endtask

    task automatic test_lost();
        ev_ready = 1'b0;
        exp_q.push_back('{16'd300, tb_ts + 32'd2, 8'd3, 1'b0});
        stim = '{0, 150, 300, 150, 0};
        repeat (12) stim.push_back(0);
        stim.push_back(200);
        stim.push_back(500);
        stim.push_back(200);
        stim.push_back(0);
        play();
        idle(14);
        n_vec++;
        if (ev_valid !== 1'b1 || ev_amplitude !== 16'sd300) begin
            n_err++;
            $display("FAIL lost_hold got=%b/%0d required=1/300", ev_valid, ev_amplitude);
        end
        n_vec++;
        if (lost_count !== 16'd1) begin
            n_err++;
            $display("FAIL lost_count got=%0d required=1", lost_count);
        end
        ev_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        n_vec++;
        if (ev_valid !== 1'b0) begin
            n_err++;
            $display("FAIL lost_pop got=%b required=0", ev_valid);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got.size() == 0) begin
                n_err++;
                $display("FAIL lost_event got=none required=%h", e);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL lost_event got=%h required=%h", g, e);
                end
            end
        end
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL lost_extra got=%0d required=0", got.size());
        end
        got.delete();
        idle(4);
    endtask

    task automatic test_reset_mid_pulse();
        stim = '{0, 150, 300};
        play();
        filter_data = 16'sd0;
        @(negedge clk);
        reset = 1'b0;
        #2;
        n_vec++;
        if ({ev_valid, ev_pileup, ev_amplitude, ev_time, ev_width, lost_count} !== 74'd0) begin
            n_err++;
            $display("FAIL midreset_outputs got=%h required=0",
                     {ev_valid, ev_pileup, ev_amplitude, ev_time, ev_width, lost_count});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        // Timestamp restarts at 0: the 300 sample is the seventh captured.
        exp_q.push_back('{16'd300, 32'd6, 8'd3, 1'b0});
        stim = '{150, 300, 200, 0};
        play();
        idle(14);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (got.size() == 0) begin
                n_err++;
                $display("FAIL midreset_event got=none required=%h", e);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    n_err++;
                    $display("FAIL midreset_event got=%h required=%h", g, e);
                end
            end
        end
        n_vec++;
        if (got.size() != 0) begin
            n_err++;
            $display("FAIL midreset_extra got=%0d required=0", got.size());
        end
        got.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_width();
        test_enable();
        test_pileup();
        test_holdoff();
        test_lost();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
